// File: rtl/round_robin_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Helpers work on 32-bit vectors; callers size the results to their own width.
package round_robin_arbiter_pkg;

  typedef enum logic {IDLE, GRANTED} state_t;

  localparam int unsigned MaxRequesters = 32;

  // Binary index of a one-hot vector (zero for an all-zero input).
  function automatic logic [31:0] onehot_to_index(logic [31:0] onehot);
    logic [31:0] index;
    index = '0;
    for (int unsigned i = 0; i < MaxRequesters; i++) begin
      if (onehot[i]) begin
        index = index | 32'(i);
      end
    end
    return index;
  endfunction

  // Eligibility mask after serving 'index': only bits strictly above it remain set.
  function automatic logic [31:0] mask_above(logic [31:0] index);
    return ~((32'd2 << index) - 32'd1);
  endfunction

endpackage

// File: rtl/first_one.sv
// Isolates the lowest set bit of a vector as a one-hot result.
// "small" is a ripple scan, "fast" uses the two's-complement trick.
module first_one #(
  parameter int unsigned WIDTH   = 4,
  parameter string       VARIANT = "fast"
) (
  input  logic [WIDTH-1:0] bits,
  output logic [WIDTH-1:0] first
);

  if (VARIANT == "small") begin : g_small
    always_comb begin
      logic found;
      first = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (bits[i] && !found) begin
          first[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end else begin : g_fast
    assign first = bits & (~bits + WIDTH'(1));
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Registered round-robin arbiter with a locked grant released by a valid/ready handshake.
// A masked first_one pass gives rotating priority; the raw pass handles wrap-around.
module round_robin_arbiter
  import round_robin_arbiter_pkg::*;
#(
  parameter int unsigned REQUESTERS  = 4,
  parameter string       VARIANT     = "fast",
  parameter int unsigned INDEX_WIDTH = $clog2(REQUESTERS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [REQUESTERS-1:0]  requests,
  output logic [REQUESTERS-1:0]  grant,
  output logic [INDEX_WIDTH-1:0] grant_index,
  output logic                   grant_valid,
  input  logic                   grant_ready
);

  state_t                 state;
  logic [REQUESTERS-1:0]  mask;
  logic [REQUESTERS-1:0]  eff_mask;
  logic [REQUESTERS-1:0]  candidates;
  logic [REQUESTERS-1:0]  masked;
  logic [REQUESTERS-1:0]  pick_masked;
  logic [REQUESTERS-1:0]  pick_raw;
  logic [REQUESTERS-1:0]  next_grant;
  logic [INDEX_WIDTH-1:0] next_index;
  logic                   transfer;

  // On a transfer the selection already uses the rotated mask, so the
  // requester just served is lowest priority for the back-to-back grant.
  always_comb begin
    transfer   = grant_valid & grant_ready;
    candidates = transfer ? (requests & ~grant) : requests;
    eff_mask   = transfer ? REQUESTERS'(mask_above(32'(grant_index))) : mask;
    masked     = candidates & eff_mask;
    next_grant = (|masked) ? pick_masked : pick_raw;
    next_index = INDEX_WIDTH'(onehot_to_index(32'(next_grant)));
  end

  first_one #(
    .WIDTH   (REQUESTERS),
    .VARIANT (VARIANT)
  ) u_first_masked (
    .bits  (masked),
    .first (pick_masked)
  );

  first_one #(
    .WIDTH   (REQUESTERS),
    .VARIANT (VARIANT)
  ) u_first_raw (
    .bits  (candidates),
    .first (pick_raw)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mask        <= '1;
      grant       <= '0;
      grant_index <= '0;
      grant_valid <= 1'b0;
    end else begin
      if (transfer) begin
        mask <= eff_mask;
      end
      case (state)
        IDLE: begin
          if (|candidates) begin
            grant       <= next_grant;
            grant_index <= next_index;
            grant_valid <= 1'b1;
            state       <= GRANTED;
          end
        end
        GRANTED: begin
          if (transfer) begin
            if (|candidates) begin
              grant       <= next_grant;
              grant_index <= next_index;
            end else begin
              grant       <= '0;
              grant_index <= '0;
              grant_valid <= 1'b0;
              state       <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// rotating-search reference model compared on every falling clock edge.
module tb_round_robin_arbiter;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] requests = '0;
  logic         grant_ready = 1'b0;
  logic [N-1:0] grant;
  logic [1:0]   grant_index;
  logic         grant_valid;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: who is granted, and who was served last (-1 = none since reset).
  bit m_busy = 1'b0;
  int m_cur  = 0;
  int m_last = -1;
  int serve_count [N];
  int wait_cnt    [N];
  bit prev_locked = 1'b0;
  logic [N-1:0] prev_grant = '0;

  round_robin_arbiter #(
    .REQUESTERS (N),
    .VARIANT    ("fast")
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .requests    (requests),
    .grant       (grant),
    .grant_index (grant_index),
    .grant_valid (grant_valid),
    .grant_ready (grant_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_grant(input string name, input logic [N-1:0] g, input int idx,
                              input logic v);
    check({name, ".grant"}, 32'(grant), 32'(g));
    check({name, ".index"}, 32'(grant_index), 32'(idx));
    check({name, ".valid"}, 32'(grant_valid), 32'(v));
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Compare process: check outputs produced by the last rising edge, then
  // advance the model with the inputs that the next rising edge will sample.
  initial begin
    for (int i = 0; i < N; i++) begin
      serve_count[i] = 0;
      wait_cnt[i]    = 0;
    end
    forever begin
      @(negedge clock);
      if (reset) begin
        m_busy      = 1'b0;
        m_cur       = 0;
        m_last      = -1;
        prev_locked = 1'b0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        check("model.reset_valid", 32'(grant_valid), 32'd0);
        check("model.reset_grant", 32'(grant), 32'd0);
      end else begin
        logic [N-1:0] eg;
        int enc;
        int excl;
        int found;
        bit xfer;
        eg = '0;
        if (m_busy) eg[m_cur] = 1'b1;
        check("model.grant", 32'(grant), 32'(eg));
        check("model.index", 32'(grant_index), m_busy ? 32'(m_cur) : 32'd0);
        check("model.valid", 32'(grant_valid), 32'(m_busy));
        enc = 0;
        for (int i = 0; i < N; i++) if (grant[i]) enc = enc | i;
        check("onehot0", 32'($onehot0(grant)), 32'd1);
        check("index_encodes_grant", 32'(grant_index), 32'(enc));
        if (prev_locked) check("locked_stable", 32'(grant), 32'(prev_grant));
        prev_locked = grant_valid && !grant_ready;
        prev_grant  = grant;
        if (grant_valid && grant_ready) begin
          for (int i = 0; i < N; i++) begin
            if (i == int'(grant_index)) wait_cnt[i] = 0;
            else if (requests[i]) begin
              wait_cnt[i]++;
              check("starvation_bound", 32'(wait_cnt[i] > 3), 32'd0);
            end
          end
        end
        xfer = m_busy && grant_ready;
        excl = -1;
        if (xfer) begin
          m_last = m_cur;
          excl   = m_cur;
          serve_count[m_cur]++;
        end
        if (!m_busy || xfer) begin
          found = -1;
          for (int j = 0; j < N; j++) begin
            int idx;
            idx = (m_last + 1 + j) % N;
            if (found < 0 && requests[idx] && idx != excl) found = idx;
          end
          m_busy = (found >= 0);
          if (found >= 0) m_cur = found;
        end
      end
    end
  end

  initial begin
    int seen [N];
    #1;
    expect_grant("reset", 4'b0000, 0, 1'b0);

    // Single requester: G, bubble, G.
    step();
    reset = 1'b0;
    requests = 4'b0001;
    grant_ready = 1'b1;
    step(); expect_grant("single.g1", 4'b0001, 0, 1'b1);
    step(); expect_grant("single.bubble", 4'b0000, 0, 1'b0);
    step(); expect_grant("single.g2", 4'b0001, 0, 1'b1);
    requests = 4'b0000;
    step(); expect_grant("single.idle", 4'b0000, 0, 1'b0);

    // All requesting: back-to-back rotation.
    reset_pulse();
    requests = 4'b1111;
    grant_ready = 1'b1;
    step(); expect_grant("rot.0", 4'b0001, 0, 1'b1);
    step(); expect_grant("rot.1", 4'b0010, 1, 1'b1);
    step(); expect_grant("rot.2", 4'b0100, 2, 1'b1);
    step(); expect_grant("rot.3", 4'b1000, 3, 1'b1);
    step(); expect_grant("rot.4", 4'b0001, 0, 1'b1);

    // Locked grant ignores new requests until consumed.
    reset_pulse();
    requests = 4'b0101;
    grant_ready = 1'b0;
    step(); expect_grant("lock.first", 4'b0001, 0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) requests = 4'b1101;
      step(); expect_grant("lock.hold", 4'b0001, 0, 1'b1);
    end
    grant_ready = 1'b1;
    step(); expect_grant("lock.next", 4'b0100, 2, 1'b1);

    // Serve index 3, then wrap around.
    step(); expect_grant("wrap.top", 4'b1000, 3, 1'b1);
    requests = 4'b1001;
    step(); expect_grant("wrap.low", 4'b0001, 0, 1'b1);
    step(); expect_grant("wrap.back", 4'b1000, 3, 1'b1);

    // Asynchronous reset mid-grant restores the all-ones mask.
    reset_pulse();
    requests = 4'b0100;
    grant_ready = 1'b0;
    step(); expect_grant("rst.held", 4'b0100, 2, 1'b1);
    step();
    reset = 1'b1;
    #1;
    expect_grant("rst.async", 4'b0000, 0, 1'b0);
    step();
    reset = 1'b0;
    requests = 4'b1100;
    step(); expect_grant("rst.after", 4'b0100, 2, 1'b1);

    // Random traffic; requests held until served, then may drop.
    for (int i = 0; i < N; i++) seen[i] = serve_count[i];
    for (int c = 0; c < 10000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (requests[i]) begin
          if (serve_count[i] != seen[i]) begin
            seen[i] = serve_count[i];
            if ($urandom_range(1, 0) == 0) requests[i] = 1'b0;
          end
        end else if ($urandom_range(2, 0) == 0) begin
          requests[i] = 1'b1;
          seen[i] = serve_count[i];
        end
      end
      grant_ready = ($urandom_range(3, 0) != 0);
    end
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
